// File: rtl/matrix_key_pkg.sv
// -----------------------------------------------------------------------------
// matrix_key_pkg
// Shared types and helpers for the matrix key scanner.
//   key_state_e : scanner FSM state (SCAN, DEBOUNCE, HELD, RELEASE)
//   code_width  : width of a key code for a ROWS x COLS matrix
// -----------------------------------------------------------------------------
package matrix_key_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } key_state_e;

  // Key code = row_index*COLS + col_index, so it needs clog2(ROWS*COLS) bits.
  function automatic int code_width(input int rows, input int cols);
    int n;
    n = rows * cols;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// -----------------------------------------------------------------------------
// key_event_fifo
// Small synchronous FIFO holding key codes until the consumer takes them.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (empties the queue)
//   push, push_data write request and data
//   pop             read request (ignored when empty)
//   pop_data        head entry, zero when empty
//   full, empty     occupancy flags
//   drop            a push was refused because the queue was full
// A push into a full queue is accepted when a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module key_event_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty,
  output logic         drop
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic         do_pop;
  logic         do_push;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  assign pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/matrix_key_scanner.sv
// -----------------------------------------------------------------------------
// matrix_key_scanner
// Scans a ROWS x COLS key matrix one active-low row at a time, debounces a
// single key, and queues key codes (row*COLS+col) for a consumer.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   col[COLS]          active-low column sense lines (asynchronous)
//   row[ROWS]          active-low one-hot row drive
//   key_valid/key_code queue head; key_ready accepts it
//   key_held           a debounced key is currently down
//   overflow/ovf_clr   sticky dropped-event flag and its clear
//   dbg_state          current scanner FSM state
// Handshake: the head transfers on a cycle where key_valid and key_ready are
// both 1; key_code holds steady while key_valid=1 and no transfer occurs;
// key_valid rises one clk after the FSM's push pulse.
// Build option: define KEY_REPEAT_EN to re-push a held key after
// REPEAT_DELAY ticks and then every REPEAT_RATE ticks
// (REPEAT_RATE <= REPEAT_DELAY).
// -----------------------------------------------------------------------------
module matrix_key_scanner
  import matrix_key_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 100,
  parameter int DEB_SCANS    = 3,
  parameter int FIFO_DEPTH   = 4,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [COLS-1:0]                    col,
  output logic [ROWS-1:0]                    row,
  output logic                               key_valid,
  output logic [code_width(ROWS, COLS)-1:0]  key_code,
  input  logic                               key_ready,
  output logic                               key_held,
  output logic                               overflow,
  input  logic                               ovf_clr,
  output key_state_e                         dbg_state
);

  localparam int CW  = code_width(ROWS, COLS);
  localparam int RW  = $clog2(ROWS);
  localparam int CLW = $clog2(COLS);
  localparam int DW  = $clog2(SCAN_DIV);
  localparam int NW  = $clog2(DEB_SCANS + 1);

  // ---------------- scan tick divider ----------------
  logic [DW-1:0] div_q;
  logic          tick;

  assign tick = (div_q == DW'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div_q <= '0;
    else if (tick) div_q <= '0;
    else           div_q <= div_q + 1'b1;
  end

  // ---------------- column synchronizer ----------------
  // Resets to all ones so an idle (released) matrix is seen after reset.
  logic [COLS-1:0] sync1_q;
  logic [COLS-1:0] sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= col;
      sync2_q <= sync1_q;
    end
  end

  // Lowest-numbered low column wins when several are pressed.
  logic           any_low;
  logic [CLW-1:0] low_idx;

  always_comb begin
    any_low = 1'b0;
    low_idx = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!sync2_q[i]) begin
        any_low = 1'b1;
        low_idx = CLW'(i);
      end
    end
  end

  // ---------------- FSM ----------------
  key_state_e     state_q;
  logic [RW-1:0]  row_idx_q;
  logic [ROWS-1:0] row_q;
  logic [CLW-1:0] col_idx_q;
  logic [NW-1:0]  cnt_q;
  logic           held_q;
  logic           push_q;
  logic [CW-1:0]  code_q;

  logic           lat_low;
  logic [NW-1:0]  cnt_inc;
  logic [RW-1:0]  row_nxt_idx;
  logic [ROWS-1:0] row_nxt_pat;

  assign lat_low     = ~sync2_q[col_idx_q];
  assign cnt_inc     = cnt_q + NW'(1);
  assign row_nxt_idx = (row_idx_q == RW'(ROWS - 1)) ? '0 : row_idx_q + 1'b1;
  assign row_nxt_pat = ~(ROWS'(1) << row_nxt_idx);

  function automatic logic [CW-1:0] key_code_of(input logic [RW-1:0]  r,
                                                input logic [CLW-1:0] c);
    return CW'(r) * CW'(COLS) + CW'(c);
  endfunction

`ifdef KEY_REPEAT_EN
  localparam int RPW = $clog2(REPEAT_DELAY + 1);
  logic [RPW-1:0] rep_q;
  logic [RPW-1:0] rep_inc;
  assign rep_inc = rep_q + RPW'(1);
`else
  // Repeat timing has no effect without auto-repeat.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_SCAN;
      row_idx_q <= '0;
      row_q     <= ~ROWS'(1);
      col_idx_q <= '0;
      cnt_q     <= '0;
      held_q    <= 1'b0;
      push_q    <= 1'b0;
      code_q    <= '0;
`ifdef KEY_REPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      push_q <= 1'b0;
      if (tick) begin
        unique case (state_q)
          ST_SCAN: begin
            if (any_low) begin
              // Lock onto this key; the row stays frozen until release.
              col_idx_q <= low_idx;
              code_q    <= key_code_of(row_idx_q, low_idx);
              if (DEB_SCANS == 1) begin
                state_q <= ST_HELD;
                held_q  <= 1'b1;
                push_q  <= 1'b1;
`ifdef KEY_REPEAT_EN
                rep_q   <= '0;
`endif
              end else begin
                state_q <= ST_DEBOUNCE;
                cnt_q   <= NW'(1);
              end
            end else begin
              row_idx_q <= row_nxt_idx;
              row_q     <= row_nxt_pat;
            end
          end
          ST_DEBOUNCE: begin
            if (!lat_low) begin
              // Bounce: rescan the same row.
              state_q <= ST_SCAN;
            end else if (cnt_inc == NW'(DEB_SCANS)) begin
              state_q <= ST_HELD;
              held_q  <= 1'b1;
              push_q  <= 1'b1;
`ifdef KEY_REPEAT_EN
              rep_q   <= '0;
`endif
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          ST_HELD: begin
            if (!lat_low) begin
              if (DEB_SCANS == 1) begin
                state_q   <= ST_SCAN;
                held_q    <= 1'b0;
                row_idx_q <= row_nxt_idx;
                row_q     <= row_nxt_pat;
              end else begin
                state_q <= ST_RELEASE;
                cnt_q   <= NW'(1);
              end
            end
`ifdef KEY_REPEAT_EN
            // Reloading to DELAY-RATE after each repeat makes the next
            // repeat land RATE ticks later without a second counter.
            else if (rep_inc == RPW'(REPEAT_DELAY)) begin
              push_q <= 1'b1;
              rep_q  <= RPW'(REPEAT_DELAY - REPEAT_RATE);
            end else begin
              rep_q <= rep_inc;
            end
`endif
          end
          ST_RELEASE: begin
            if (lat_low) begin
              state_q <= ST_HELD;
            end else if (cnt_inc == NW'(DEB_SCANS)) begin
              state_q   <= ST_SCAN;
              held_q    <= 1'b0;
              row_idx_q <= row_nxt_idx;
              row_q     <= row_nxt_pat;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        endcase
      end
    end
  end

  assign row       = row_q;
  assign key_held  = held_q;
  assign dbg_state = state_q;

  // ---------------- event queue ----------------
  logic fifo_full;
  logic fifo_empty;
  logic fifo_drop;

  key_event_fifo #(
    .W     (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q),
    .push_data (code_q),
    .pop       (key_valid & key_ready),
    .pop_data  (key_code),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  assign key_valid = ~fifo_empty;

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            ovf_q <= 1'b0;
    else if (fifo_drop) ovf_q <= 1'b1;
    else if (ovf_clr)   ovf_q <= 1'b0;
  end

  assign overflow = ovf_q;

endmodule

// File: tb/tb_matrix_key_scanner.sv
// -----------------------------------------------------------------------------
// tb_matrix_key_scanner
// Directed bench for matrix_key_scanner (4x4, SCAN_DIV=4, DEB_SCANS=3,
// FIFO_DEPTH=4, REPEAT_DELAY=5, REPEAT_RATE=2). A key matrix model turns
// pressed keys plus the driven row into column levels. Inputs change #1
// after a rising edge; outputs are read there or on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_matrix_key_scanner;
  import matrix_key_pkg::*;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [COLS-1:0]      col;
  logic [ROWS-1:0]      row;
  logic                 key_valid;
  logic [3:0]           key_code;
  logic                 key_ready = 1'b0;
  logic                 key_held;
  logic                 overflow;
  logic                 ovf_clr = 1'b0;
  key_state_e           dbg_state;
  logic [ROWS*COLS-1:0] pressed = '0;

  matrix_key_scanner #(
    .ROWS         (ROWS),
    .COLS         (COLS),
    .SCAN_DIV     (4),
    .DEB_SCANS    (3),
    .FIFO_DEPTH   (4),
    .REPEAT_DELAY (5),
    .REPEAT_RATE  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .row       (row),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .key_held  (key_held),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .dbg_state (dbg_state)
  );

  // Key matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (pressed[r*COLS+c] && !row[r]) col[c] = 1'b0;
  end

  // Reference clock count since reset release; scan ticks land on multiples of 4.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];
  int         exp_cyc_q[$];
  int         extra_cnt = 0;

  always @(negedge clk) begin
    if (!rst && key_valid && key_ready) begin
      if (exp_q.size() == 0) begin
        extra_cnt++;
      end else begin
        check("evt_code", 32'(key_code), 32'(exp_q.pop_front()));
        if (exp_cyc_q.size() > 0) check("evt_cyc", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    pressed   = '0;
    key_ready = 1'b0;
    ovf_clr   = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    extra_cnt = 0;
    step(2);
    rst = 1'b0;
  endtask

  // Press a key, wait for acceptance, then one more clk so queue flags settle.
  task automatic press_key(input int r, input int c);
    int n;
    n = 0;
    pressed[r*COLS+c] = 1'b1;
    while (!key_held && n < 400) begin step(1); n++; end
    check("held_rise", 32'(key_held), 32'd1);
    step(1);
  endtask

  task automatic release_key(input int r, input int c);
    int n;
    n = 0;
    pressed[r*COLS+c] = 1'b0;
    while (key_held && n < 400) begin step(1); n++; end
    check("held_fall", 32'(key_held), 32'd0);
  endtask

  // Press just after the tick that selects row r, so acceptance falls
  // exactly 3 ticks (12 clk) later.
  task automatic press_aligned(input int r, input int c);
    int n;
    logic [ROWS-1:0] want;
    n    = 0;
    want = ~(ROWS'(1) << r);
    while (!(row == want && cyc % 4 == 0 && cyc != 0) && n < 200) begin step(1); n++; end
    check("row_align", 32'(row), 32'(want));
    pressed[r*COLS+c] = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [ROWS-1:0] row_seq [5];

  initial begin
    row_seq[0] = 4'b1110; row_seq[1] = 4'b1101; row_seq[2] = 4'b1011;
    row_seq[3] = 4'b0111; row_seq[4] = 4'b1110;

    // Reset state and idle scanning.
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(2);
    check("rst_row",   32'(row), 32'b1110);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_code",  32'(key_code), 32'd0);
    check("rst_held",  32'(key_held), 32'd0);
    check("rst_ovf",   32'(overflow), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_SCAN));
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("idle_row", 32'(row), 32'(row_seq[i]));
      check("idle_valid", 32'(key_valid), 32'd0);
      if (i < 4) step(4);
    end

    // Key row2/col1 held 20 ticks; one event (plus repeats when enabled).
    do_reset();
    key_ready = 1'b1;
    exp_q.push_back(4'd9);
`ifdef KEY_REPEAT_EN
    for (int n = 1; n <= 15; n++)
      if (n >= 5 && (n - 5) % 2 == 0) exp_q.push_back(4'd9);
`endif
    pressed[2*COLS+1] = 1'b1;
    step(16);
    check("deb_held",  32'(key_held), 32'd0);
    check("deb_row",   32'(row), 32'b1011);
    check("deb_state", 32'(dbg_state), 32'(ST_DEBOUNCE));
    step(4);
    check("acc_held",  32'(key_held), 32'd1);
    check("acc_valid_lat", 32'(key_valid), 32'd0);
    step(1);
    check("acc_valid", 32'(key_valid), 32'd1);
    check("acc_code",  32'(key_code), 32'd9);
    step(59);
    pressed[2*COLS+1] = 1'b0;
    step(8);
    check("rel_held",  32'(key_held), 32'd1);
    check("rel_state", 32'(dbg_state), 32'(ST_RELEASE));
    step(4);
    check("rel_done",  32'(key_held), 32'd0);
    check("rel_row",   32'(row), 32'b0111);
    step(8);
    check("s39_left",  exp_q.size(), 0);
    check("s39_extra", extra_cnt, 0);

    // Bounce: col1 low 2 ticks on row0, then high.
    do_reset();
    key_ready = 1'b1;
    pressed[1] = 1'b1;
    step(8);
    check("bnc_state", 32'(dbg_state), 32'(ST_DEBOUNCE));
    pressed[1] = 1'b0;
    step(4);
    check("bnc_scan",  32'(dbg_state), 32'(ST_SCAN));
    check("bnc_row",   32'(row), 32'b1110);
    check("bnc_held",  32'(key_held), 32'd0);
    step(4);
    check("bnc_adv",   32'(row), 32'b1101);
    step(8);
    check("bnc_valid", 32'(key_valid), 32'd0);
    check("bnc_extra", extra_cnt, 0);

    // Five presses with no consumer: four queued, overflow, clear, set-wins,
    // then a push into the full queue while it pops.
    do_reset();
    exp_q.push_back(4'd0);  exp_q.push_back(4'd6);
    exp_q.push_back(4'd15); exp_q.push_back(4'd8);
    press_key(0, 0); release_key(0, 0);
    check("q1_ovf", 32'(overflow), 32'd0);
    press_key(1, 2); release_key(1, 2);
    press_key(3, 3); release_key(3, 3);
    press_key(2, 0); release_key(2, 0);
    check("q4_ovf",   32'(overflow), 32'd0);
    check("q4_valid", 32'(key_valid), 32'd1);
    check("q4_head",  32'(key_code), 32'd0);
    press_key(0, 3);
    check("q5_ovf",   32'(overflow), 32'd1);
    check("q5_head",  32'(key_code), 32'd0);
    release_key(0, 3);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);
    ovf_clr = 1'b1;
    press_key(1, 0);
    check("ovf_set_wins", 32'(overflow), 32'd1);
    step(1);
    check("ovf_clr_after", 32'(overflow), 32'd0);
    ovf_clr = 1'b0;
    release_key(1, 0);
    press_aligned(1, 1);
    step(12);
    check("fp_held", 32'(key_held), 32'd1);
    key_ready = 1'b1;
    step(1);
    key_ready = 1'b0;
    check("fp_ovf",  32'(overflow), 32'd0);
    check("fp_head", 32'(key_code), 32'd6);
    exp_q.push_back(4'd5);
    release_key(1, 1);
    key_ready = 1'b1;
    step(10);
    check("drain_left",  exp_q.size(), 0);
    check("drain_valid", 32'(key_valid), 32'd0);
    check("drain_extra", extra_cnt, 0);

    // Reset during DEBOUNCE with two events queued.
    do_reset();
    press_key(0, 0); release_key(0, 0);
    press_key(1, 1); release_key(1, 1);
    check("mr_valid_pre", 32'(key_valid), 32'd1);
    press_aligned(3, 2);
    step(4);
    check("mr_state_pre", 32'(dbg_state), 32'(ST_DEBOUNCE));
    rst = 1'b1;
    #1;
    check("mr_valid", 32'(key_valid), 32'd0);
    check("mr_row",   32'(row), 32'b1110);
    check("mr_state", 32'(dbg_state), 32'(ST_SCAN));
    pressed = '0;
    step(1);
    rst = 1'b0;
    key_ready = 1'b1;
    step(40);
    check("mr_after_valid", 32'(key_valid), 32'd0);
    check("mr_after_extra", extra_cnt, 0);

    // Key 0 held 12 ticks past acceptance; event timing checked per clk.
    do_reset();
    key_ready = 1'b1;
    exp_q.push_back(4'd0); exp_cyc_q.push_back(13);
`ifdef KEY_REPEAT_EN
    exp_q.push_back(4'd0); exp_cyc_q.push_back(33);
    exp_q.push_back(4'd0); exp_cyc_q.push_back(41);
    exp_q.push_back(4'd0); exp_cyc_q.push_back(49);
    exp_q.push_back(4'd0); exp_cyc_q.push_back(57);
`endif
    pressed[0] = 1'b1;
    step(60);
    check("rp_held", 32'(key_held), 32'd1);
    pressed[0] = 1'b0;
    step(16);
    check("rp_done",  32'(key_held), 32'd0);
    check("rp_left",  exp_q.size(), 0);
    check("rp_extra", extra_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/matrix_key_scanner.md
MATRIX_KEY_SCANNER -- requirements
Module: matrix_key_scanner

Interface
REQ-001 The module SHALL have parameter ROWS, default 4, meaning the number of row drive lines (2..8).
REQ-002 The module SHALL have parameter COLS, default 4, meaning the number of column sense lines (2..8).
REQ-003 The module SHALL have parameter SCAN_DIV, default 100, meaning clk cycles per scan tick (>=2).
REQ-004 The module SHALL have parameter DEB_SCANS, default 3, meaning consecutive matching scan ticks needed to accept a press or release (>=1).
REQ-005 The module SHALL have parameter FIFO_DEPTH, default 4, meaning key-event queue entries (power of 2, >=2).
REQ-006 The module SHALL have parameter REPEAT_DELAY, default 50, meaning ticks before first auto-repeat; used only with KEY_REPEAT_EN.
REQ-007 The module SHALL have parameter REPEAT_RATE, default 10, meaning ticks between subsequent repeats; used only with KEY_REPEAT_EN.
REQ-008 The module SHALL have port clk, input, 1 bit, meaning the single clock.
REQ-009 The module SHALL have port rst, input, 1 bit, meaning the asynchronous active-high reset.
REQ-010 The module SHALL have port col, input, COLS bits, meaning active-low column sense lines, asynchronous to clk.
REQ-011 The module SHALL have port row, output, ROWS bits, meaning active-low one-hot row drive.
REQ-012 The module SHALL have port key_valid, output, 1 bit, meaning the queue head is valid.
REQ-013 The module SHALL have port key_code, output, $clog2(ROWS*COLS) bits, meaning the queue head code, equal to row_index*COLS+col_index.
REQ-014 The module SHALL have port key_ready, input, 1 bit, meaning the consumer accepts the head.
REQ-015 The module SHALL have port key_held, output, 1 bit, meaning a debounced key is currently down.
REQ-016 The module SHALL have port overflow, output, 1 bit, meaning sticky: an event was dropped.
REQ-017 The module SHALL have port ovf_clr, input, 1 bit, meaning clear overflow.

Function
REQ-018 The module SHALL pulse an internal tick when its divider counter (0..SCAN_DIV-1) equals SCAN_DIV-1, and SHALL then wrap the counter to 0.
REQ-019 The module SHALL pass col through a 2-flop synchronizer and SHALL evaluate it only on tick.
REQ-020 The FSM SHALL have states SCAN, DEBOUNCE, HELD and RELEASE.
REQ-021 In SCAN, on each tick with no synchronized column low, the module SHALL advance the row index, wrapping ROWS-1 to 0.
REQ-022 In SCAN, on a tick with any column low, the module SHALL latch the lowest low column index, freeze the row, and enter DEBOUNCE with count 1.
REQ-023 In DEBOUNCE, the count SHALL increment on each tick with the latched column still low, the FSM SHALL return to SCAN (row not advanced) if that column is high, and the FSM SHALL enter HELD and push the code when the count reaches DEB_SCANS.
REQ-024 If DEB_SCANS=1, the module SHALL push the event on the same tick that latches the column.
REQ-025 In HELD, the FSM SHALL enter RELEASE on a tick with the latched column high, and key_held SHALL be 1 only in HELD and RELEASE.
REQ-026 In RELEASE, the FSM SHALL count consecutive high ticks, SHALL return to HELD on any low tick, and SHALL go to SCAN with the row advanced on reaching DEB_SCANS.
REQ-027 The module SHALL ignore other keys while it is locked on a latched key.
REQ-028 The queue SHALL use a ready/valid handshake: a pop occurs when key_valid and key_ready are both 1; key_code SHALL be stable while key_valid=1 and no pop occurs; latency from push to key_valid SHALL be 1 clk.
REQ-029 If the queue is full and a pop occurs in the same cycle as a push, the module SHALL accept the push.
REQ-030 If the queue is full with no pop, the module SHALL drop the push and set overflow.
REQ-031 If a set and ovf_clr occur in the same cycle, the set SHALL win.

Reset
REQ-032 While rst is asserted, the module SHALL hold state SCAN, row index 0, row equal to all ones except bit0=0, divider 0, queue empty, key_valid=0, key_code=0, key_held=0, overflow=0, and synchronizer flops all ones.
REQ-033 Reset asserted mid-operation SHALL discard queued events and any debounce in progress.

Configuration
REQ-034 With KEY_REPEAT_EN defined, HELD SHALL count ticks and SHALL re-push the code at REPEAT_DELAY and then every REPEAT_RATE ticks, with the count cleared when HELD is entered from DEBOUNCE.
REQ-035 Without KEY_REPEAT_EN, there SHALL be exactly one push per press, and the repeat counter logic SHALL be absent.

Structure
REQ-036 Package matrix_key_pkg SHALL hold the FSM state enum and the code-width helper function.
REQ-037 The queue SHALL be a sub-module named key_event_fifo, parametrised by width and depth, with push/pop/full/empty signals.

Verification (ROWS=4, COLS=4, SCAN_DIV=4, DEB_SCANS=3, FIFO_DEPTH=4)
REQ-038 Scenario: reset, then idle -> row cycles 1110,1101,1011,0111,1110 every 4 clk, and key_valid=0.
REQ-039 Scenario: hold key row2/col1 for 20 ticks, key_ready=1 -> one event with key_code=9, key_held rising after the third matching tick.
REQ-040 Scenario: col1 low for 2 ticks, then bounce high -> no event, and the FSM returns to SCAN.
REQ-041 Scenario: 5 distinct presses with key_ready=0 -> 4 queued in order, overflow=1, a later ovf_clr clears it.
REQ-042 Scenario: assert rst during DEBOUNCE with 2 events queued -> key_valid=0 and row=1110 immediately.
REQ-043 Scenario: with KEY_REPEAT_EN, REPEAT_DELAY=5, REPEAT_RATE=2, hold key code 0 for 12 ticks after acceptance -> pushes at acceptance, +5, +7, +9 and +11 ticks.
